// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state encoding, stream field widths and the checksum fold helper live here.
package mem_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
  localparam int unsigned BCNT_W     = $clog2(WORD_BYTES);
  localparam int unsigned CSUM_W     = 8;
  localparam int unsigned LEN_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  // XOR of the bytes of one word; each word folds into the running checksum.
  function automatic logic [CSUM_W-1:0] xor_fold(input logic [WORD_W-1:0] w);
    logic [CSUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      acc = acc ^ w[i*BYTE_W +: BYTE_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface inst_mem_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler: the first byte of a word ends up in [31:24].
// word_valid pulses for one cycle after the last byte of a word is shifted in.
module word_assembler
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic [BCNT_W-1:0] byte_cnt
);

  localparam logic [BCNT_W-1:0] LAST = BCNT_W'(WORD_BYTES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_valid <= 1'b0;
      word       <= '0;
      byte_cnt   <= '0;
    end else if (clr) begin
      word_valid <= 1'b0;
      word       <= '0;
      byte_cnt   <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        word       <= {word[WORD_W-BYTE_W-1:0], byte_in};
        byte_cnt   <= byte_cnt + BCNT_W'(1);
        word_valid <= (byte_cnt == LAST);
      end
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a MIPS program image from a byte stream into instruction memory,
// holding the CPU stalled until the image is written and its checksum verified.
module inst_mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  inst_mem_loader_if.master  bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

  state_t              state;
  logic [BYTE_W-1:0]   cnt_hi;
  logic [LEN_W-1:0]    count;
  logic [IDX_W-1:0]    word_index;
  logic [CSUM_W-1:0]   csum;

  logic                word_valid;
  logic [WORD_W-1:0]   word;
  logic [BCNT_W-1:0]   byte_cnt;

  logic                accept_c;
  logic                rearm_c;
  logic [LEN_W-1:0]    n_c;
  logic [CSUM_W-1:0]   csum_nxt_c;

  always_comb begin
    accept_c   = bus.rx_valid && bus.rx_ready;
    rearm_c    = start && ((state == ST_DONE) || (state == ST_ERR));
    n_c        = {cnt_hi, bus.rx_data};
    // The last word's fold lands on the same edge the checksum byte may arrive.
    csum_nxt_c = word_valid ? (csum ^ xor_fold(word)) : csum;
  end

  word_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (rearm_c),
    .byte_en    (accept_c && (state == ST_DATA)),
    .byte_in    (bus.rx_data),
    .word_valid (word_valid),
    .word       (word),
    .byte_cnt   (byte_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cnt_hi        <= '0;
      count         <= '0;
      word_index    <= '0;
      csum          <= '0;
      bus.rx_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      csum       <= csum_nxt_c;

      // Memory write trails the 4th byte by one cycle, whatever the state.
      if (word_valid) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= ADDR_W'(word_index) << 2;
        bus.mem_wdata <= word;
        word_index    <= word_index + IDX_W'(1);
      end

      case (state)
        ST_IDLE: begin
          state        <= ST_CNT_HI;
          bus.rx_ready <= 1'b1;
        end
        ST_CNT_HI: begin
          if (accept_c) begin
            cnt_hi <= bus.rx_data;
            state  <= ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          if (accept_c) begin
            count <= n_c;
            if (n_c > LEN_W'(DEPTH)) begin
              state        <= ST_ERR;
              error        <= 1'b1;
              bus.rx_ready <= 1'b0;
            end else if (n_c == '0) begin
              state <= ST_CHK;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept_c && (byte_cnt == BCNT_W'(WORD_BYTES - 1)) &&
              (LEN_W'(word_index) == count - LEN_W'(1))) begin
            state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (accept_c) begin
            bus.rx_ready <= 1'b0;
            if (bus.rx_data == csum_nxt_c) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_CNT_HI;
            bus.rx_ready <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
            word_index   <= '0;
            csum         <= '0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          bus.rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writes a MIPS program image into the writable instruction memory from an 8-bit byte stream, holding the pipeline stalled until the image is complete and verified. It sits between an external byte source (UART receiver or testbench driver) and the instruction memory write port. The memory read side is unchanged: it indexes words by `address[31:2]`, so this block emits word-aligned byte addresses.

## Interface
Parameters:
- `DEPTH`, 64: instruction memory depth in 32-bit words. The maximum legal word count.
- `ADDR_W`, 32: width of `mem_addr`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; re-arms loading from DONE or ERR.
- `rx_valid`  in  1  byte source has a byte.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte. A byte transfers when `rx_valid && rx_ready` on a clock edge.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  byte address of the write, equal to word_index<<2.
- `mem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  keeps the pipeline stalled and reset while high.
- `done`  out  1  image loaded and checksum matched; sticky.
- `error`  out  1  overflow or checksum mismatch; sticky.

## Operation
- Stream format:
  - 2-byte word count N, big-endian.
  - 4·N data bytes. Each word is big-endian: the first byte goes to [31:24].
  - 1 checksum byte equal to the XOR of all data bytes. The count bytes are excluded.
- States:
  - IDLE: the reset state. Goes to CNT_HI unconditionally on the next edge.
  - CNT_HI: captures the count high byte, then goes to CNT_LO.
  - CNT_LO: captures the count low byte.
    - N > DEPTH: go to ERR.
    - N == 0: go to CHK.
    - Otherwise: go to DATA.
  - DATA: assembles bytes into a word using a 2-bit byte counter.
    - On the 4th byte: issue a write, increment word_index, and XOR all four bytes into the running checksum.
    - After word N-1 is written, go to CHK.
  - CHK: if the byte equals the running checksum, go to DONE. Otherwise go to ERR.
  - DONE: `done`=1, `cpu_hold`=0.
  - ERR: `error`=1, `cpu_hold`=1.
  - From DONE or ERR, `start` goes to CNT_HI. This clears done, error, word_index, checksum and the byte counter, and raises `cpu_hold`.
- `start` is ignored in every other state.
- `rx_ready` = 1 exactly in CNT_HI, CNT_LO, DATA and CHK. It is decoded from the state, with no dependence on `rx_valid`.
- Gaps in `rx_valid` hold all state. Partial-word bytes are kept.
- Writes that completed before an ERR are not undone.
- word_index is log2(DEPTH)+1 bits wide. `mem_addr` is that index zero-extended and shifted left by 2.

## Timing
- Reset values:
  - state IDLE, `rx_ready` 0, `mem_we` 0.
  - `mem_addr` 0, `mem_wdata` 0.
  - `cpu_hold` 1, `done` 0, `error` 0.
  - All internal counters and the checksum are 0.
- `rx_ready` first rises on the 1st edge after `reset_n` deasserts.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered and asserted on the edge after the 4th byte of a word is accepted, for exactly 1 cycle. `mem_addr` and `mem_wdata` hold their values until the next write.
- Back-to-back words are written at most 1 write per 4 accepted bytes. No write port stall is needed.
- Checksum result: `done` or `error` rises 1 cycle after the checksum byte is accepted. `cpu_hold` falls in the same cycle `done` rises.
- Overflow: `error` rises 1 cycle after the count low byte is accepted, with no writes.
- Reset mid-load: every output returns to its reset value immediately (asynchronous). The next load starts at word 0 with an empty assembler.

## Structure
- Shared package `mem_loader_pkg` holds:
  - the state encoding (IDLE, CNT_HI, CNT_LO, DATA, CHK, DONE, ERR);
  - the checksum width;
  - the word-size constant (4 bytes).
- Sub-module `word_assembler`: a byte shift register plus a 2-bit counter. It outputs `word_valid` and a 32-bit word, and has a synchronous clear driven by `start`.
- The FSM, word_index, checksum and memory-port registers live in the top.

## Test plan
- Load 2 words with stream 00 02 12 34 56 78 9A BC DE F0 00:
  - `mem_we` pulses with addr 0x0 / data 0x12345678, then addr 0x4 / data 0x9ABCDEF0.
  - `done`=1 and `cpu_hold`=0 one cycle after the final byte.
- Same image with checksum byte 01:
  - both writes still occur;
  - `error`=1, `done`=0, `cpu_hold`=1, `rx_ready`=0.
- Count 00 41 (65 > 64):
  - `error`=1 one cycle after the second byte;
  - zero `mem_we` pulses.
- Count 00 00, then checksum 00:
  - `done`=1 with no writes.
  - A `start` pulse then clears `done`, raises `cpu_hold`, and a fresh 1-word load writes addr 0x0.
- Test 1 stream with random 0–5 cycle `rx_valid` gaps:
  - identical writes, addresses and completion;
  - `start` pulses injected mid-load are ignored.
- Assert `reset_n` low after 2 data bytes of word 0:
  - all outputs return to reset values immediately;
  - a subsequent full load writes 0x12345678 at addr 0x0.
